// File: rtl/mac_accel_if.sv
// Purpose: processor-bus view of the mac_accel register file (strobes, address, data, interrupt).
// Latency: none here; the slave registers read data one cycle after the read strobe.
// Backpressure: none; the bus has no wait states.
// Ports: iChipSelect_n/iWrite_n/iRead_n active-low strobes, iAddress word address,
//        iData write data, oData registered read data, oIrq interrupt.
interface mac_accel_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              iChipSelect_n;
    logic              iWrite_n;
    logic              iRead_n;
    logic [ADDR_W-1:0] iAddress;
    logic [DATA_W-1:0] iData;
    logic [DATA_W-1:0] oData;
    logic              oIrq;

    modport master (
        output iChipSelect_n, iWrite_n, iRead_n, iAddress, iData,
        input  oData, oIrq
    );

    modport slave (
        input  iChipSelect_n, iWrite_n, iRead_n, iAddress, iData,
        output oData, oIrq
    );
endinterface

// File: rtl/mac_accel.sv
// Purpose: memory-mapped SUM / PRODUCT (shift-add) / DOT accelerator with status and interrupt.
// Latency: SUM NUM_OPS+1, PRODUCT DATA_W+3, DOT (NUM_OPS/2)*(DATA_W+2)+1, reserved 1 cycle.
// Backpressure: none; operand and CTRL writes are dropped while the engine is busy.
// Ports: iClk clock, iReset async active-high reset, bus = mac_accel_if slave
//        (OP[0..NUM_OPS-1], CTRL, RESULT_LO, RESULT_HI, STATUS at consecutive word addresses).
module mac_accel #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 4,
    parameter int ADDR_W  = 4
) (
    input  logic      iClk,
    input  logic      iReset,
    mac_accel_if.slave bus
);
    localparam int ACC_W = 2 * DATA_W;
    localparam int IDX_W = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1;
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(NUM_OPS);
    localparam logic [ADDR_W-1:0] A_RES_LO = ADDR_W'(NUM_OPS + 1);
    localparam logic [ADDR_W-1:0] A_RES_HI = ADDR_W'(NUM_OPS + 2);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_OPS + 3);

    localparam logic [1:0] M_SUM = 2'd0;
    localparam logic [1:0] M_PRODUCT = 2'd1;
    localparam logic [1:0] M_DOT = 2'd2;

    typedef enum logic [2:0] {IDLE, SUM, LOAD, SHIFT, ACC, FINISH} state_t;

    state_t             state;
    logic [DATA_W-1:0]  op [NUM_OPS];
    logic [1:0]         mode;
    logic               irqEn;
    logic               busy, done, overflow, error;
    logic [ACC_W-1:0]   acc, product, result;
    logic [DATA_W-1:0]  mcand, mplier;
    logic [IDX_W-1:0]   opIdx;
    logic [CNT_W-1:0]   bitCnt;
    logic [DATA_W-1:0]  rdMux;
    logic [ACC_W:0]     accSum;
    logic [ACC_W-1:0]   shiftedMcand;

    wire wrEn    = !bus.iChipSelect_n && !bus.iWrite_n;
    wire rdEn    = !bus.iChipSelect_n && !bus.iRead_n;
    wire isOp    = bus.iAddress < A_CTRL;
    wire ctrlWr  = wrEn && (bus.iAddress == A_CTRL);
    wire startOk = ctrlWr && bus.iData[3] && (state == IDLE);

    // Carry out of the 2*DATA_W accumulator drives the sticky overflow flag.
    assign accSum       = {1'b0, acc} + {1'b0, product};
    assign shiftedMcand = {{DATA_W{1'b0}}, mcand} << bitCnt;

    always_comb begin
        rdMux = '0;
        if (isOp) begin
            rdMux = op[bus.iAddress[IDX_W-1:0]];
        end else begin
            case (bus.iAddress)
                A_CTRL:   rdMux = {{(DATA_W-3){1'b0}}, irqEn, mode};
                A_RES_LO: rdMux = result[DATA_W-1:0];
                A_RES_HI: rdMux = result[ACC_W-1:DATA_W];
                A_STATUS: rdMux = {{(DATA_W-4){1'b0}}, error, overflow, done, busy};
                default:  rdMux = '0;
            endcase
        end
    end

    assign bus.oIrq = done & irqEn;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state    <= IDLE;
            for (int i = 0; i < NUM_OPS; i++) op[i] <= '0;
            mode     <= '0;
            irqEn    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            error    <= 1'b0;
            acc      <= '0;
            product  <= '0;
            result   <= '0;
            mcand    <= '0;
            mplier   <= '0;
            opIdx    <= '0;
            bitCnt   <= '0;
            bus.oData <= '0;
        end else begin
            // Register-file writes; operands and CTRL are frozen while the engine runs.
            if (wrEn && isOp && state == IDLE)
                op[bus.iAddress[IDX_W-1:0]] <= bus.iData;
            if (ctrlWr && state == IDLE) begin
                mode  <= bus.iData[1:0];
                irqEn <= bus.iData[2];
            end
            if (wrEn && bus.iAddress == A_STATUS && bus.iData[1])
                done <= 1'b0;

            // Read data samples pre-edge state, so a RESULT read on the FINISH edge sees the old value.
            if (rdEn)
                bus.oData <= rdMux;

            // Engine; assignments below override the W1C above so a same-edge set of done wins.
            case (state)
                IDLE: begin
                    if (startOk) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        error    <= 1'b0;
                        acc      <= '0;
                        opIdx    <= '0;
                        case (bus.iData[1:0])
                            M_SUM:               state <= SUM;
                            M_PRODUCT, M_DOT:    state <= LOAD;
                            default:             state <= FINISH;
                        endcase
                    end
                end
                SUM: begin
                    acc <= acc + {{DATA_W{1'b0}}, op[opIdx]};
                    if (opIdx == IDX_W'(NUM_OPS - 1))
                        state <= FINISH;
                    else
                        opIdx <= opIdx + IDX_W'(1);
                end
                LOAD: begin
                    mcand   <= op[opIdx];
                    mplier  <= op[opIdx + IDX_W'(1)];
                    product <= '0;
                    bitCnt  <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (mplier[0])
                        product <= product + shiftedMcand;
                    mplier <= mplier >> 1;
                    if (bitCnt == CNT_W'(DATA_W - 1))
                        state <= ACC;
                    else
                        bitCnt <= bitCnt + CNT_W'(1);
                end
                ACC: begin
                    acc <= accSum[ACC_W-1:0];
                    if (accSum[ACC_W])
                        overflow <= 1'b1;
                    // PRODUCT stops after the first pair; DOT walks every pair.
                    if (mode == M_PRODUCT || opIdx == IDX_W'(NUM_OPS - 2)) begin
                        state <= FINISH;
                    end else begin
                        opIdx <= opIdx + IDX_W'(2);
                        state <= LOAD;
                    end
                end
                FINISH: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    if (mode == 2'd3)
                        error <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_accel.sv
// Purpose: randomized scoreboard bench for mac_accel against an arithmetic reference model.
// Latency: polls STATUS every cycle of an operation to pin the exact done edge.
// Backpressure: none; read expectations queue up and a monitor retires them one cycle later.
module tb_mac_accel;
    localparam int DATA_W  = 32;
    localparam int NUM_OPS = 4;
    localparam int ADDR_W  = 4;
    localparam logic [3:0] A_CTRL = 4'd4, A_RLO = 4'd5, A_RHI = 4'd6, A_STAT = 4'd7;

    logic iClk = 1'b0;
    logic iReset = 1'b1;
    always #5 iClk = ~iClk;

    mac_accel_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mac_accel #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W)) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] expQ[$];
    logic [31:0] maskQ[$];
    string       nameQ[$];

    logic [31:0] opv [NUM_OPS];
    logic [63:0] prevRes = '0;
    logic        rdSeen = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: a read strobe seen on an edge means oData holds the answer at the next negedge.
    always @(posedge iClk)
        rdSeen <= !iReset && !bus.iChipSelect_n && !bus.iRead_n;

    always @(negedge iClk) begin
        if (rdSeen) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read got=%h exp=<none>", bus.oData);
            end else begin
                logic [31:0] e, m;
                string nm;
                e = expQ.pop_front();
                m = maskQ.pop_front();
                nm = nameQ.pop_front();
                check(nm, bus.oData & m, e & m);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // All bus tasks are entered at a negedge and return at the following negedge.
    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        bus.iChipSelect_n = 1'b0; bus.iWrite_n = 1'b0; bus.iRead_n = 1'b1;
        bus.iAddress = a; bus.iData = d;
        @(negedge iClk);
        bus.iChipSelect_n = 1'b1; bus.iWrite_n = 1'b1;
    endtask

    task automatic busRead(input logic [3:0] a, input logic [31:0] e, input logic [31:0] m, input string nm);
        expQ.push_back(e); maskQ.push_back(m); nameQ.push_back(nm);
        bus.iChipSelect_n = 1'b0; bus.iRead_n = 1'b0; bus.iWrite_n = 1'b1;
        bus.iAddress = a;
        @(negedge iClk);
        bus.iChipSelect_n = 1'b1; bus.iRead_n = 1'b1;
    endtask

    // edgeTest: 0 none, 1 read RESULT_LO on the done edge, 2 clear done on the done edge.
    // interfere: mid-run writes of OP0=100 and a SUM start, both of which must be dropped.
    task automatic runOp(input logic [3:0] ctrl, input int edgeTest, input bit interfere);
        logic [66:0] total;
        logic [63:0] expRes;
        logic        ovf, err;
        int          lat;
        total = '0; ovf = 1'b0; err = 1'b0; lat = 0;
        case (ctrl[1:0])
            2'd0: begin
                for (int i = 0; i < NUM_OPS; i++) total += 67'(opv[i]);
                lat = NUM_OPS + 1;
            end
            2'd1: begin
                total = 67'(opv[0]) * 67'(opv[1]);
                lat = DATA_W + 3;
            end
            2'd2: begin
                for (int i = 0; i < NUM_OPS / 2; i++) total += 67'(opv[2*i]) * 67'(opv[2*i+1]);
                lat = (NUM_OPS / 2) * (DATA_W + 2) + 1;
            end
            default: begin
                err = 1'b1;
                lat = 1;
            end
        endcase
        expRes = total[63:0];
        ovf = (total[66:64] != 3'd0);

        for (int i = 0; i < NUM_OPS; i++) busWrite(4'(i), opv[i]);
        busWrite(A_CTRL, {28'd0, ctrl});
        for (int t = 1; t <= lat + 2; t++) begin
            if (interfere && t == 3)
                busWrite(4'd0, 32'd100);
            else if (interfere && t == 4)
                busWrite(A_CTRL, 32'h8);
            else if (edgeTest == 1 && t == lat)
                busRead(A_RLO, prevRes[31:0], 32'hFFFF_FFFF, "rlo_on_done_edge");
            else if (edgeTest == 2 && t == lat)
                busWrite(A_STAT, 32'h2);
            else
                busRead(A_STAT, {30'd0, t > lat, t <= lat}, 32'h3, "status_poll");
        end
        busRead(A_RLO, expRes[31:0], 32'hFFFF_FFFF, "result_lo");
        busRead(A_RHI, expRes[63:32], 32'hFFFF_FFFF, "result_hi");
        busRead(A_STAT, {28'd0, err, ovf, 2'b10}, 32'hFFFF_FFFF, "status_done");
        busRead(A_CTRL, {29'd0, ctrl[2:0]}, 32'hFFFF_FFFF, "ctrl_readback");
        busRead(4'd0, opv[0], 32'hFFFF_FFFF, "op0_readback");
        check("irq_on_done", {31'd0, bus.oIrq}, {31'd0, ctrl[2]});
        busWrite(A_STAT, 32'h2);
        check("irq_after_clear", {31'd0, bus.oIrq}, 32'd0);
        busRead(A_STAT, {28'd0, err, ovf, 2'b00}, 32'hFFFF_FFFF, "status_cleared");
        prevRes = expRes;
    endtask

    initial begin
        bus.iChipSelect_n = 1'b1; bus.iWrite_n = 1'b1; bus.iRead_n = 1'b1;
        bus.iAddress = '0; bus.iData = '0;
        repeat (3) @(negedge iClk);
        check("reset_odata", bus.oData, 32'd0);
        check("reset_irq", {31'd0, bus.oIrq}, 32'd0);
        iReset = 1'b0;
        @(negedge iClk);
        for (int a = 0; a < 10; a++) busRead(4'(a), 32'd0, 32'hFFFF_FFFF, "reset_reg");

        // Unmapped writes are dropped and unmapped reads return 0.
        busWrite(4'd9, 32'hDEAD_BEEF);
        busRead(4'd9, 32'd0, 32'hFFFF_FFFF, "unmapped_read");

        opv = '{32'd1, 32'd2, 32'd3, 32'd4};
        runOp(4'h8, 1, 1'b0);
        opv = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        runOp(4'h9, 2, 1'b0);
        opv = '{32'd3, 32'd5, 32'd7, 32'd11};
        runOp(4'hE, 0, 1'b0);
        opv = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        runOp(4'hA, 1, 1'b0);
        opv = '{32'd6, 32'd7, 32'd9, 32'd13};
        runOp(4'h9, 0, 1'b1);
        runOp(4'hF, 2, 1'b0);

        // Reset mid-DOT aborts everything.
        opv = '{32'd12, 32'd34, 32'd56, 32'd78};
        for (int i = 0; i < NUM_OPS; i++) busWrite(4'(i), opv[i]);
        busWrite(A_CTRL, 32'hE);
        repeat (9) @(negedge iClk);
        iReset = 1'b1;
        repeat (2) @(negedge iClk);
        check("midrun_reset_irq", {31'd0, bus.oIrq}, 32'd0);
        check("midrun_reset_odata", bus.oData, 32'd0);
        iReset = 1'b0;
        @(negedge iClk);
        for (int a = 0; a < 8; a++) busRead(4'(a), 32'd0, 32'hFFFF_FFFF, "midrun_reset_reg");
        prevRes = '0;

        for (int n = 0; n < 12; n++) begin
            logic [3:0] c;
            c = {1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            for (int i = 0; i < NUM_OPS; i++)
                opv[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            runOp(c, $urandom_range(0, 2), 1'b0);
        end

        repeat (3) @(negedge iClk);
        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_accel.md
Name: mac_accel

Overview:
- Parametrised memory-mapped arithmetic accelerator on the processor bus, successor to the fixed four-operand adder peripheral.
- Holds NUM_OPS operand registers plus control, 2×DATA_W result and status registers.
- Multi-cycle engine computes SUM, PRODUCT (shift-add) or DOT (sum of pairwise products), with done/overflow/error status and an interrupt.

Parameters:
- DATA_W, 32, operand width in bits; also bus data width.
- NUM_OPS, 4, number of operand registers; even, 2..(2^ADDR_W − 4).
- ADDR_W, 4, address width in bits.

Ports:
- iClk  in  1  system clock.
- iReset  in  1  asynchronous, active-high reset.
- iChipSelect_n  in  1  active-low chip select.
- iWrite_n  in  1  active-low write strobe.
- iRead_n  in  1  active-low read strobe.
- iAddress  in  ADDR_W  word address.
- iData  in  DATA_W  write data.
- oData  out  DATA_W  registered read data.
- oIrq  out  1  interrupt = done & irq_en.

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous and active-high on iReset. On reset: all operands, CTRL, result, STATUS and oData = 0, oIrq = 0, FSM = IDLE, counters = 0. Reset mid-operation aborts immediately; no partial result is kept.
- Register map:
  - 0..NUM_OPS−1: OP[i], RW.
  - NUM_OPS: CTRL, RW. Bits [1:0] mode (0 SUM, 1 PRODUCT, 2 DOT, 3 reserved); bit 2 irq_en; bit 3 start, write-only, self-clearing, reads 0.
  - NUM_OPS+1: RESULT_LO, RO.
  - NUM_OPS+2: RESULT_HI, RO.
  - NUM_OPS+3: STATUS. Bit 0 busy (RO); bit 1 done (sticky, write 1 to clear); bit 2 overflow (RO); bit 3 error (RO).
- Bus access:
  - Write takes effect on the iClk edge where iChipSelect_n = 0 and iWrite_n = 0.
  - Read: oData updates on the edge where iChipSelect_n = 0 and iRead_n = 0, one cycle latency. It holds its value otherwise.
  - Unmapped addresses read 0; writes to them are ignored.
- Start: a CTRL write with bit 3 = 1 while IDLE latches mode and irq_en, clears the accumulator, done, overflow and error, and sets busy on that edge.
  - Start while busy is ignored entirely; CTRL is not updated.
  - A CTRL write with bit 3 = 0 updates mode/irq_en only when IDLE.
- While busy, writes to OP[i] are ignored, so operands stay stable.
- FSM states: IDLE, SUM, LOAD, SHIFT, ACC, FINISH.
  - SUM: acc += zero-extended OP[idx], one operand per cycle, idx 0..NUM_OPS−1, then FINISH.
  - LOAD: multiplicand = OP[2k], multiplier = OP[2k+1], product = 0, bit counter = 0.
  - SHIFT: DATA_W cycles. If multiplier LSB = 1, product += multiplicand << count. Multiplier shifts right each cycle.
  - ACC: {carry, acc} = acc + product. carry = 1 sets overflow (sticky). Then k++; go to LOAD if k < pairs, else FINISH.
  - FINISH: RESULT = acc, done = 1, busy = 0, go to IDLE.
- Pair count: PRODUCT uses pairs = 1 (OP0×OP1). DOT uses pairs = NUM_OPS/2.
- Mode 3: go straight to FINISH. Result = 0, error = 1.
- Arithmetic:
  - Unsigned throughout; accumulator is 2×DATA_W bits and wraps.
  - SUM never overflows (requires NUM_OPS ≤ 2^DATA_W).
- Latency, counted from the start-write edge to the edge that sets done:
  - SUM: NUM_OPS+1.
  - PRODUCT: DATA_W+3.
  - DOT: (NUM_OPS/2)×(DATA_W+2)+1.
  - Reserved mode: 1.
- Simultaneous events:
  - Write-1-to-clear of done on the same edge that FINISH sets done: done stays 1 (set wins).
  - Read of RESULT on the FINISH edge returns the previous result.
- oIrq: combinational AND of done and the latched irq_en; deasserts when done is cleared or a new start is accepted.

Test Plan:
- SUM: OP = 1,2,3,4, write CTRL = 0x8 → busy at next read, done 5 cycles after start; RESULT_LO = 10, RESULT_HI = 0, STATUS = 0x2.
- PRODUCT: OP0 = OP1 = 0xFFFFFFFF, CTRL = 0x9 → done after 35 cycles; RESULT_HI = 0xFFFFFFFE, RESULT_LO = 0x00000001, overflow = 0.
- DOT: OP = 3,5,7,11, CTRL = 0xE (irq_en) → oIrq rises 69 cycles after start, RESULT_LO = 92. Write STATUS = 0x2 → done = 0, oIrq = 0.
- DOT overflow: all OP = 0xFFFFFFFF, CTRL = 0xA → overflow = 1, RESULT_HI = 0xFFFFFFFC, RESULT_LO = 0x00000002.
- Busy protection: start PRODUCT with 6×7, then write OP0 = 100 and CTRL = 0x8 mid-run → both ignored; result 42, mode still reads 1.
- Reserved/reset: CTRL = 0xB → done and error after 1 cycle, result 0. Start DOT, assert iReset at cycle 10 → all registers 0, busy = 0, oIrq = 0; a new start after release works.
